// File: rtl/bus_write_checker.sv
// Bus write checker: compares CPU writes inside an address window against a
// FIFO of expected (address, data) entries and keeps pass/fail statistics.
module bus_write_checker #(
  parameter int          DEPTH        = 8,
  parameter logic [15:0] WIN_LO       = 16'h0200,
  parameter logic [15:0] WIN_HI       = 16'h02FF,
  parameter bit          HALT_ON_FAIL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [15:0]                exp_addr,
  input  logic [7:0]                 exp_data,
  input  logic [15:0]                AB,
  input  logic [7:0]                 DO,
  input  logic                       WE,
  input  logic                       RDY,
  output logic                       pass_pulse,
  output logic                       fail_pulse,
  output logic [15:0]                tot_cnt,
  output logic [15:0]                pass_cnt,
  output logic [15:0]                fail_cnt,
  output logic [15:0]                last_fail_addr,
  output logic [7:0]                 last_fail_data,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_CHECK  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [15:0]     addr_mem_r [DEPTH];
  logic [7:0]      data_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic            ready_r;
  logic            pass_r;
  logic            fail_r;
  logic [15:0]     tot_r;
  logic [15:0]     passc_r;
  logic [15:0]     failc_r;
  logic [15:0]     lfa_r;
  logic [7:0]      lfd_r;
  logic            halted_r;

  logic            watched_s;
  logic            check_s;
  logic            push_s;
  logic            pop_s;
  logic            match_s;
  logic            fail_s;
  logic [15:0]     head_addr_s;
  logic [7:0]      head_data_s;

  // Qualify the bus cycle, decide push/pop and the next occupancy and state.
  always_comb begin
    watched_s   = WE && RDY && (AB >= WIN_LO) && (AB <= WIN_HI);
    check_s     = watched_s && (state_r == ST_CHECK);
    push_s      = exp_valid && ready_r;
    pop_s       = check_s && (count_r != {CW{1'b0}});
    head_addr_s = addr_mem_r[rd_ptr_r];
    head_data_s = data_mem_r[rd_ptr_r];
    match_s     = pop_s && (head_addr_s == AB) && (head_data_s == DO);
    // An empty FIFO turns any checked write into an unexpected-write failure.
    fail_s      = check_s && !match_s;

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase

    case (state_r)
      ST_CHECK: begin
        if (fail_s && (HALT_ON_FAIL == 1'b1)) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_CHECK;
    endcase
  end

  // Expected-entry storage; contents are invalidated by the pointers, not reset.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      addr_mem_r[wr_ptr_r] <= exp_addr;
      data_mem_r[wr_ptr_r] <= exp_data;
    end
  end

  // Control state, FIFO pointers, pulses and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_CHECK;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b1;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
      tot_r    <= 16'h0000;
      passc_r  <= 16'h0000;
      failc_r  <= 16'h0000;
      lfa_r    <= 16'h0000;
      lfd_r    <= 8'h00;
      halted_r <= 1'b0;
    end else if (clear) begin
      state_r  <= ST_CHECK;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b1;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
      tot_r    <= 16'h0000;
      passc_r  <= 16'h0000;
      failc_r  <= 16'h0000;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == ST_HALTED);
      count_r  <= count_nxt_s;
      ready_r  <= (count_nxt_s < DEPTH_C);
      pass_r   <= match_s;
      fail_r   <= fail_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (match_s || fail_s) begin
        tot_r <= sat_inc(tot_r);
      end
      if (match_s) begin
        passc_r <= sat_inc(passc_r);
      end
      if (fail_s) begin
        failc_r <= sat_inc(failc_r);
        lfa_r   <= AB;
        lfd_r   <= DO;
      end
    end
  end

  assign exp_ready      = ready_r;
  assign pass_pulse     = pass_r;
  assign fail_pulse     = fail_r;
  assign tot_cnt        = tot_r;
  assign pass_cnt       = passc_r;
  assign fail_cnt       = failc_r;
  assign last_fail_addr = lfa_r;
  assign last_fail_data = lfd_r;
  assign pending        = count_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_bus_write_checker.sv
// Self-checking bench: two checkers (HALT_ON_FAIL 0 and 1) share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_bus_write_checker;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        exp_valid;
  logic [15:0] exp_addr;
  logic [7:0]  exp_data;
  logic [15:0] ab;
  logic [7:0]  dout;
  logic        we;
  logic        rdy;

  logic        ready [2];
  logic        pp    [2];
  logic        fp    [2];
  logic [15:0] tot   [2];
  logic [15:0] pc    [2];
  logic [15:0] fc    [2];
  logic [15:0] lfa   [2];
  logic [7:0]  lfd   [2];
  logic [3:0]  pend  [2];
  logic        hlt   [2];

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t        mq     [2][$];
  int          m_tot  [2];
  int          m_pass [2];
  int          m_fail [2];
  bit          m_halt [2];
  bit          m_pp   [2];
  bit          m_fp   [2];
  logic [15:0] m_lfa  [2];
  logic [7:0]  m_lfd  [2];
  bit          hof    [2];

  bus_write_checker #(.DEPTH(DEPTH), .WIN_LO(16'h0200), .WIN_HI(16'h02FF), .HALT_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(ready[0]), .exp_addr(exp_addr), .exp_data(exp_data),
    .AB(ab), .DO(dout), .WE(we), .RDY(rdy),
    .pass_pulse(pp[0]), .fail_pulse(fp[0]),
    .tot_cnt(tot[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0]),
    .last_fail_addr(lfa[0]), .last_fail_data(lfd[0]),
    .pending(pend[0]), .halted(hlt[0])
  );

  bus_write_checker #(.DEPTH(DEPTH), .WIN_LO(16'h0200), .WIN_HI(16'h02FF), .HALT_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(ready[1]), .exp_addr(exp_addr), .exp_data(exp_data),
    .AB(ab), .DO(dout), .WE(we), .RDY(rdy),
    .pass_pulse(pp[1]), .fail_pulse(fp[1]),
    .tot_cnt(tot[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1]),
    .last_fail_addr(lfa[1]), .last_fail_data(lfd[1]),
    .pending(pend[1]), .halted(hlt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_tot[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_halt[i] = 1'b0; m_pp[i] = 1'b0; m_fp[i] = 1'b0;
      m_lfa[i] = 16'h0000; m_lfd[i] = 8'h00;
    end
  endtask

  // One clock edge of the checker rules, applied to the inputs currently driven.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit   watched;
      bit   push_ok;
      ent_t h;
      if (clear) begin
        mq[i].delete();
        m_tot[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
        m_halt[i] = 1'b0; m_pp[i] = 1'b0; m_fp[i] = 1'b0;
      end else begin
        push_ok = exp_valid && (mq[i].size() < DEPTH);
        watched = we && rdy && (ab >= 16'h0200) && (ab <= 16'h02FF);
        m_pp[i] = 1'b0;
        m_fp[i] = 1'b0;
        if (watched && !m_halt[i]) begin
          if (mq[i].size() > 0) begin
            h = mq[i].pop_front();
            if (h.a == ab && h.d == dout) m_pp[i] = 1'b1;
            else m_fp[i] = 1'b1;
          end else begin
            m_fp[i] = 1'b1;
          end
        end
        if (push_ok) mq[i].push_back({exp_addr, exp_data});
        if (m_pp[i]) begin
          m_pass[i] = sat(m_pass[i]);
          m_tot[i]  = sat(m_tot[i]);
        end
        if (m_fp[i]) begin
          m_fail[i] = sat(m_fail[i]);
          m_tot[i]  = sat(m_tot[i]);
          m_lfa[i]  = ab;
          m_lfd[i]  = dout;
          if (hof[i]) m_halt[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("exp_ready", i, 32'(ready[i]), 32'(mq[i].size() < DEPTH));
      chk("pass_pulse", i, 32'(pp[i]), 32'(m_pp[i]));
      chk("fail_pulse", i, 32'(fp[i]), 32'(m_fp[i]));
      chk("tot_cnt", i, 32'(tot[i]), m_tot[i]);
      chk("pass_cnt", i, 32'(pc[i]), m_pass[i]);
      chk("fail_cnt", i, 32'(fc[i]), m_fail[i]);
      chk("last_fail_addr", i, 32'(lfa[i]), 32'(m_lfa[i]));
      chk("last_fail_data", i, 32'(lfd[i]), 32'(m_lfd[i]));
      chk("pending", i, 32'(pend[i]), mq[i].size());
      chk("halted", i, 32'(hlt[i]), 32'(m_halt[i]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    clear = 1'b0; exp_valid = 1'b0; exp_addr = 16'h0000; exp_data = 8'h00;
    ab = 16'h0000; dout = 8'h00; we = 1'b0; rdy = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    we = 1'b1; rdy = 1'b1; ab = a; dout = d;
  endtask

  task automatic wr_head();
    ent_t e;
    if (mq[0].size() > 0) begin
      e = mq[0][0];
      wr(e.a, e.d);
    end else begin
      wr(16'h0200, 8'h00);
    end
  endtask

  initial begin
    logic [15:0] bnd [4];
    int          sel;
    bnd[0] = 16'h01FF; bnd[1] = 16'h0200; bnd[2] = 16'h02FF; bnd[3] = 16'h0300;
    hof[0] = 1'b0; hof[1] = 1'b1;
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_ready", 0, 32'(ready[0]), 32'd1);
    chk("rst_pending", 1, 32'(pend[1]), 32'd0);
    reset = 1'b0;
    step();

    // Matching write passes.
    push(16'h0200, 8'hA5); step(); idle();
    wr(16'h0200, 8'hA5); step(); idle();
    chk("pass_basic", 0, 32'(pp[0]), 32'd1);
    chk("pass_cnt_basic", 0, 32'(pc[0]), 32'd1);
    step();
    chk("pulse_one_cycle", 0, 32'(pp[0]), 32'd0);

    // Data mismatch fails and records the failing cycle; halting instance stops.
    push(16'h0201, 8'h11); step(); idle();
    wr(16'h0201, 8'h12); step(); idle();
    chk("fail_basic", 0, 32'(fp[0]), 32'd1);
    chk("last_fail_data", 0, 32'(lfd[0]), 32'h12);
    chk("halt_on_fail", 1, 32'(hlt[1]), 32'd1);

    // Halted instance ignores matching writes but still accepts pushes.
    push(16'h0202, 8'h5A); step(); idle();
    wr(16'h0202, 8'h5A); step(); idle();
    chk("halted_no_pulse", 1, 32'(pp[1]), 32'd0);
    chk("halted_tot_frozen", 1, 32'(tot[1]), 32'd2);
    chk("halted_pending", 1, 32'(pend[1]), 32'd1);
    clear = 1'b1; step(); idle();
    chk("clear_halted", 1, 32'(hlt[1]), 32'd0);
    chk("clear_tot", 1, 32'(tot[1]), 32'd0);

    // Unexpected write with a same-cycle push: no bypass; out-of-window ignored.
    push(16'h0250, 8'h33); wr(16'h0250, 8'h33); step(); idle();
    chk("unexpected_fail", 0, 32'(fp[0]), 32'd1);
    chk("unexpected_pending", 0, 32'(pend[0]), 32'd1);
    wr(16'h0300, 8'h33); step(); idle();
    chk("outside_no_fail", 0, 32'(fp[0]), 32'd0);
    wr(16'h01FF, 8'h33); step(); idle();
    wr_head(); step(); idle();
    clear = 1'b1; step(); idle();

    // Fill, refused push on a popping cycle, then wrap the pointers twice.
    for (int k = 0; k < DEPTH; k++) begin
      push(16'h0200 + 16'(k), 8'($urandom_range(0, 255))); step();
    end
    idle();
    chk("full_ready", 0, 32'(ready[0]), 32'd0);
    chk("full_pending", 0, 32'(pend[0]), 32'd8);
    push(16'h02AA, 8'hAA); wr_head(); step(); idle();
    chk("full_push_refused", 0, 32'(pend[0]), 32'd7);
    for (int k = 0; k < 16; k++) begin
      push(16'h0280 + 16'(k), 8'($urandom_range(0, 255))); wr_head(); step(); idle();
    end
    chk("wrap_pass_cnt", 0, 32'(pc[0]), 32'd17);
    for (int k = 0; k < 7; k++) begin
      wr_head(); step(); idle();
    end

    // Asynchronous reset between edges with entries pending.
    for (int k = 0; k < 3; k++) begin
      push(16'h0210 + 16'(k), 8'(k)); step();
    end
    idle();
    chk("pre_reset_pending", 0, 32'(pend[0]), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_pending", 0, 32'(pend[0]), 32'd0);
    chk("async_ready", 0, 32'(ready[0]), 32'd1);
    chk("async_pending", 1, 32'(pend[1]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      clear = ($urandom_range(0, 99) < 3);
      exp_valid = 1'($urandom_range(0, 1));
      exp_addr = 16'h0200 + 16'($urandom_range(0, 3));
      exp_data = 8'($urandom_range(0, 3));
      we  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      if (sel == 0 && mq[0].size() > 0) begin
        ab = mq[0][0].a; dout = mq[0][0].d;
      end else if (sel == 1) begin
        ab = 16'h0200 + 16'($urandom_range(0, 3)); dout = 8'($urandom_range(0, 3));
      end else if (sel == 2) begin
        ab = bnd[$urandom_range(0, 3)]; dout = 8'($urandom_range(0, 255));
      end else begin
        ab = 16'($urandom_range(0, 65535)); dout = 8'($urandom_range(0, 255));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_write_checker.md
BUS_WRITE_CHECKER -- requirements
Module: bus_write_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 8, expected-write FIFO entries (power of two, 2..64)
- WIN_LO, 16'h0200, lowest watched address (inclusive)
- WIN_HI, 16'h02FF, highest watched address (inclusive)
- HALT_ON_FAIL, 0, 1 = stop checking after the first failure
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous: flush FIFO, zero counters, leave HALTED
- exp_valid  in  1  expected-write entry offered
- exp_ready  out  1  FIFO can accept an entry
- exp_addr  in  16  expected address
- exp_data  in  8  expected data
- AB  in  16  CPU address bus
- DO  in  8  CPU write data
- WE  in  1  CPU write enable
- RDY  in  1  CPU bus cycle qualifier
- pass_pulse  out  1  one-cycle pulse: watched write matched
- fail_pulse  out  1  one-cycle pulse: watched write mismatched or unexpected
- tot_cnt  out  16  checked writes
- pass_cnt  out  16  passes
- fail_cnt  out  16  failures
- last_fail_addr  out  16  AB of the most recent failure
- last_fail_data  out  8  DO of the most recent failure
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- halted  out  1  checker in HALTED state

Function
REQ-003 Push SHALL occur on a rising clk edge with exp_valid && exp_ready; exp_ready SHALL equal (pending < DEPTH) and SHALL NOT depend on a same-cycle pop.
REQ-004 A watched write SHALL be WE && RDY && WIN_LO <= AB <= WIN_HI; writes outside the window, and reads, SHALL be ignored.
REQ-005 States SHALL be CHECK and HALTED; reset and clear SHALL enter CHECK.
REQ-006 In CHECK, a watched write with pending > 0 SHALL pop the FIFO head; pass SHALL be declared if AB == head addr and DO == head data, fail otherwise.
REQ-007 In CHECK, a watched write with pending == 0 SHALL be a fail (unexpected write) and SHALL NOT pop; a same-cycle push SHALL NOT be compared (no bypass).
REQ-008 pass_pulse/fail_pulse SHALL be registered, asserted exactly one cycle after the qualifying edge, and mutually exclusive.
REQ-009 Counters SHALL update on the same edge as the pulse registers, SHALL saturate at 16'hFFFF, and tot_cnt SHALL increment on every pass or fail.
REQ-010 On a fail, last_fail_addr/last_fail_data SHALL capture AB/DO of the failing cycle.
REQ-011 With HALT_ON_FAIL=1, a fail SHALL move CHECK->HALTED; in HALTED, watched writes SHALL be ignored (no pop, no pulse, no count), pushes SHALL still be accepted, halted SHALL be 1.
REQ-012 With HALT_ON_FAIL=0, HALTED SHALL be unreachable.
REQ-013 Simultaneous push and pop SHALL leave pending unchanged and keep FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-014 clear SHALL take priority over push, pop and counting in the same cycle.

Reset
REQ-015 While reset is high, outputs SHALL be: exp_ready=1, pass_pulse=0, fail_pulse=0, all counters 0, last_fail_addr=16'h0000, last_fail_data=8'h00, pending=0, halted=0.
REQ-016 Reset asserted mid-operation SHALL discard FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-017 Push (0x0200,0xA5); watched write AB=0x0200 DO=0xA5 -> pass_pulse one cycle later, pass_cnt=1, tot_cnt=1, pending=0.
REQ-018 Push (0x0201,0x11); write AB=0x0201 DO=0x12 -> fail_pulse, fail_cnt=1, last_fail_addr=0x0201, last_fail_data=0x12, pending=0.
REQ-019 Empty FIFO; write AB=0x0250 with a same-cycle push -> fail_pulse (unexpected), pending=1 afterward; write AB=0x0300 -> no pulse.
REQ-020 Push 8 entries (DEPTH=8) -> exp_ready=0, pending=8; push+pop in the same cycle -> push refused, pending=7; 16 pass cycles exercise pointer wrap with correct order.
REQ-021 HALT_ON_FAIL=1: mismatch -> halted=1; next matching write -> no pulse, counters frozen; clear -> halted=0, all counters 0, pending=0.
REQ-022 Assert reset asynchronously with pending=3 between edges -> pending=0 and exp_ready=1 before the next clk edge.
